// File: rtl/uart_pkg.sv
// Shared UART FIFO definitions: byte width and FIFO controller state encoding.
package uart_pkg;

  localparam int unsigned UART_DW   = 8;
  localparam int unsigned TXF_SW    = 1;

  localparam logic [TXF_SW-1:0] TXF_IDLE  = 1'b0;
  localparam logic [TXF_SW-1:0] TXF_OFFER = 1'b1;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x byte register array: synchronous write, asynchronous read.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [UART_DW-1:0]    wr_data,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [UART_DW-1:0]    rd_data_c
);

  localparam int unsigned DEPTH = 32'd1 << DEPTH_LOG2;

  logic [UART_DW-1:0] mem_q [DEPTH];

  // Storage is intentionally not reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data_c = mem_q[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO feeding the UART transmitter's valid/ack handshake,
// with level/status reporting and a sticky overflow flag.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2   = 4,
  parameter int unsigned ALMOST_EMPTY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [UART_DW-1:0]    wr_data,
  input  logic                  wr_en,
  input  logic                  flush,
  input  logic                  tx_en,
  input  logic                  ovf_clr,
  output logic [UART_DW-1:0]    tx_data,
  output logic                  tx_data_valid,
  input  logic                  tx_data_ack,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  idle,
  output logic                  overflow
);

  localparam int unsigned DEPTH = 32'd1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  logic [TXF_SW-1:0]  state_q, state_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [UART_DW-1:0] tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               ovf_q, ovf_d;

  logic               has_room;
  logic               wr_ok;
  logic               ovf_set;
  logic               can_load;
  logic               pop;
  logic [UART_DW-1:0] rd_data;

  uart_fifo_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk       (clk),
    .wr_en     (wr_ok),
    .wr_addr   (wr_ptr_q),
    .wr_data   (wr_data),
    .rd_addr   (rd_ptr_q),
    .rd_data_c (rd_data)
  );

  // Room is judged on the pre-edge count, so a same-cycle pop never frees a slot.
  always_comb begin
    has_room = (count_q < CW'(DEPTH));
    wr_ok    = wr_en && !flush && has_room;
    ovf_set  = wr_en && !flush && !has_room;
    can_load = (count_q != '0) && tx_en && !flush;
  end

  // Offer FSM plus pointer/count bookkeeping.
  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    pop        = 1'b0;

    case (state_q)
      TXF_IDLE: begin
        tx_valid_d = 1'b0;
        if (can_load) begin
          tx_data_d  = rd_data;
          tx_valid_d = 1'b1;
          pop        = 1'b1;
          state_d    = TXF_OFFER;
        end
      end
      TXF_OFFER: begin
        if (tx_data_ack) begin
          if (can_load) begin
            tx_data_d = rd_data;
            pop       = 1'b1;
          end else begin
            tx_valid_d = 1'b0;
            state_d    = TXF_IDLE;
          end
        end
      end
      default: begin
        tx_valid_d = 1'b0;
        state_d    = TXF_IDLE;
      end
    endcase

    if (flush) begin
      count_d  = '0;
      wr_ptr_d = rd_ptr_q;
    end else begin
      if (wr_ok) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(wr_ok) - CW'(pop);
    end

    // A dropped write outranks a same-cycle clear.
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= TXF_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      ovf_q      <= ovf_d;
    end
  end

  assign tx_data       = tx_data_q;
  assign tx_data_valid = tx_valid_q;
  assign overflow      = ovf_q;
  assign level         = count_q;
  assign full          = (count_q == CW'(DEPTH));
  assign empty         = (count_q == '0);
  assign almost_empty  = (count_q <= CW'(ALMOST_EMPTY));
  assign idle          = (count_q == '0) && (state_q == TXF_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       flush;
  logic       tx_en;
  logic       ovf_clr;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       tx_data_ack;
  logic [4:0] level;
  logic       full;
  logic       empty;
  logic       almost_empty;
  logic       idle;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  uart_tx_fifo #(.DEPTH_LOG2(4), .ALMOST_EMPTY(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_data       (wr_data),
    .wr_en         (wr_en),
    .flush         (flush),
    .tx_en         (tx_en),
    .ovf_clr       (ovf_clr),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_ack   (tx_data_ack),
    .level         (level),
    .full          (full),
    .empty         (empty),
    .almost_empty  (almost_empty),
    .idle          (idle),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_data = d;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 0; wr_data = 0; flush = 0; tx_en = 0; ovf_clr = 0; tx_data_ack = 0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%0h exp=0", tx_data); end
    checks++; if (tx_data_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", tx_data_valid); end
    checks++; if (level !== 5'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if ({full, empty, almost_empty, idle, overflow} !== 5'b01110) begin
      failures++; $display("FAIL reset_status got=%b exp=01110", {full, empty, almost_empty, idle, overflow}); end
  endtask

  task automatic test_single();
    tx_en = 1'b1;
    push(8'hA5);
    checks++; if (level !== 5'd1 || tx_data_valid !== 1'b0) begin
      failures++; $display("FAIL single_edge0 level=%0d valid=%0b exp level=1 valid=0", level, tx_data_valid); end
    tick();
    checks++; if (tx_data_valid !== 1'b1 || tx_data !== 8'hA5) begin
      failures++; $display("FAIL single_offer valid=%0b data=%0h exp valid=1 data=a5", tx_data_valid, tx_data); end
    checks++; if (level !== 5'd0 || idle !== 1'b0) begin
      failures++; $display("FAIL single_level level=%0d idle=%0b exp level=0 idle=0", level, idle); end
    tx_data_ack = 1'b1; tick(); tx_data_ack = 1'b0;
    checks++; if (tx_data_valid !== 1'b0 || idle !== 1'b1) begin
      failures++; $display("FAIL single_ack valid=%0b idle=%0b exp valid=0 idle=1", tx_data_valid, idle); end
  endtask

  task automatic test_burst();
    tx_en = 1'b0;
    for (int i = 1; i <= 16; i++) push(8'(i));
    checks++; if (level !== 5'd16 || full !== 1'b1 || almost_empty !== 1'b0 || empty !== 1'b0) begin
      failures++; $display("FAIL burst_full level=%0d full=%0b ae=%0b empty=%0b exp 16/1/0/0", level, full, almost_empty, empty); end
    // Write while full with a same-cycle pop and a same-cycle clear.
    wr_data = 8'hEE; wr_en = 1'b1; ovf_clr = 1'b1; tx_en = 1'b1;
    tick();
    wr_en = 1'b0;
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL burst_ovf_set got=%0b exp=1", overflow); end
    checks++; if (level !== 5'd15 || tx_data_valid !== 1'b1 || tx_data !== 8'h01) begin
      failures++; $display("FAIL burst_first level=%0d valid=%0b data=%0h exp 15/1/01", level, tx_data_valid, tx_data); end
    tick();
    ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL burst_ovf_clr got=%0b exp=0", overflow); end
    for (int k = 1; k <= 16; k++) begin
      checks++; if (tx_data_valid !== 1'b1 || tx_data !== 8'(k)) begin
        failures++; $display("FAIL burst_byte%0d valid=%0b data=%0h exp valid=1 data=%0h", k, tx_data_valid, tx_data, k); end
      repeat (19) tick();
      tx_data_ack = 1'b1; tick(); tx_data_ack = 1'b0;
    end
    checks++; if (tx_data_valid !== 1'b0 || idle !== 1'b1 || empty !== 1'b1) begin
      failures++; $display("FAIL burst_drain valid=%0b idle=%0b empty=%0b exp 0/1/1", tx_data_valid, idle, empty); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_q[$];
    logic [7:0] e;
    int         rcv = 0;
    bit         saw_full = 0;
    bit         ae_bad = 0;
    bit         order_bad = 0;
    for (int r = 0; r < 8; r++) begin
      tx_en = 1'b0;
      for (int j = 0; j < 5; j++) begin
        e = 8'(8'h40 + r * 5 + j);
        exp_q.push_back(e);
        push(e);
        if (full) saw_full = 1;
        if (j == 1 && almost_empty !== 1'b1) ae_bad = 1;
        if (j == 2 && almost_empty !== 1'b0) ae_bad = 1;
      end
      tx_en = 1'b1;
      tick();
      for (int k = 0; k < 8 && tx_data_valid === 1'b1; k++) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
        if (tx_data !== e) order_bad = 1;
        rcv++;
        if (full) saw_full = 1;
        tx_data_ack = 1'b1; tick(); tx_data_ack = 1'b0;
      end
    end
    checks++; if (rcv != 40) begin failures++; $display("FAIL wrap_count got=%0d exp=40", rcv); end
    checks++; if (order_bad) begin failures++; $display("FAIL wrap_order got=out_of_order exp=in_order"); end
    checks++; if (saw_full) begin failures++; $display("FAIL wrap_full got=1 exp=0"); end
    checks++; if (ae_bad) begin failures++; $display("FAIL wrap_almost_empty got=wrong_at_level_2_or_3 exp=1_then_0"); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL wrap_idle got=%0b exp=1", idle); end
  endtask

  task automatic test_tx_en_gating();
    tx_en = 1'b0;
    push(8'h21); push(8'h22); push(8'h23);
    tick();
    checks++; if (level !== 5'd3 || tx_data_valid !== 1'b0) begin
      failures++; $display("FAIL gate_hold level=%0d valid=%0b exp 3/0", level, tx_data_valid); end
    tx_en = 1'b1; tick();
    checks++; if (tx_data_valid !== 1'b1 || tx_data !== 8'h21 || level !== 5'd2) begin
      failures++; $display("FAIL gate_offer valid=%0b data=%0h level=%0d exp 1/21/2", tx_data_valid, tx_data, level); end
    tx_en = 1'b0; tick(); tick();
    checks++; if (tx_data_valid !== 1'b1 || tx_data !== 8'h21) begin
      failures++; $display("FAIL gate_keep valid=%0b data=%0h exp 1/21", tx_data_valid, tx_data); end
    tx_data_ack = 1'b1; tick(); tx_data_ack = 1'b0;
    checks++; if (tx_data_valid !== 1'b0 || level !== 5'd2 || idle !== 1'b0) begin
      failures++; $display("FAIL gate_ack valid=%0b level=%0d idle=%0b exp 0/2/0", tx_data_valid, level, idle); end
    flush = 1'b1; tick(); flush = 1'b0;
    checks++; if (level !== 5'd0 || idle !== 1'b1) begin
      failures++; $display("FAIL gate_flush level=%0d idle=%0b exp 0/1", level, idle); end
  endtask

  task automatic test_flush();
    tx_en = 1'b0;
    for (int i = 0; i < 6; i++) push(8'(8'h11 + i));
    tx_en = 1'b1; tick();
    checks++; if (tx_data !== 8'h11 || level !== 5'd5) begin
      failures++; $display("FAIL flush_setup data=%0h level=%0d exp 11/5", tx_data, level); end
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'h99; tick();
    flush = 1'b0; wr_en = 1'b0;
    checks++; if (level !== 5'd0 || overflow !== 1'b0) begin
      failures++; $display("FAIL flush_clear level=%0d ovf=%0b exp 0/0", level, overflow); end
    tick();
    checks++; if (tx_data_valid !== 1'b1 || tx_data !== 8'h11) begin
      failures++; $display("FAIL flush_keep valid=%0b data=%0h exp 1/11", tx_data_valid, tx_data); end
    tx_data_ack = 1'b1; tick(); tx_data_ack = 1'b0;
    checks++; if (tx_data_valid !== 1'b0 || idle !== 1'b1) begin
      failures++; $display("FAIL flush_ack valid=%0b idle=%0b exp 0/1", tx_data_valid, idle); end
    push(8'h77); tick();
    checks++; if (tx_data_valid !== 1'b1 || tx_data !== 8'h77) begin
      failures++; $display("FAIL flush_next valid=%0b data=%0h exp 1/77", tx_data_valid, tx_data); end
    tx_en = 1'b0;
    push(8'h78); push(8'h79);
    tx_en = 1'b1; flush = 1'b1; tx_data_ack = 1'b1; tick();
    flush = 1'b0; tx_data_ack = 1'b0;
    checks++; if (tx_data_valid !== 1'b0 || level !== 5'd0 || idle !== 1'b1) begin
      failures++; $display("FAIL flush_with_ack valid=%0b level=%0d idle=%0b exp 0/0/1", tx_data_valid, level, idle); end
  endtask

  task automatic test_reset_mid();
    tx_en = 1'b0;
    for (int i = 0; i < 5; i++) push(8'(8'h31 + i));
    tx_en = 1'b1; tick();
    checks++; if (tx_data_valid !== 1'b1 || level !== 5'd4) begin
      failures++; $display("FAIL rstmid_setup valid=%0b level=%0d exp 1/4", tx_data_valid, level); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (tx_data_valid !== 1'b0 || tx_data !== 8'h00 || level !== 5'd0) begin
      failures++; $display("FAIL rstmid_out valid=%0b data=%0h level=%0d exp 0/00/0", tx_data_valid, tx_data, level); end
    checks++; if ({full, empty, almost_empty, idle, overflow} !== 5'b01110) begin
      failures++; $display("FAIL rstmid_status got=%b exp=01110", {full, empty, almost_empty, idle, overflow}); end
    push(8'h3C); tick();
    checks++; if (tx_data_valid !== 1'b1 || tx_data !== 8'h3C || level !== 5'd0) begin
      failures++; $display("FAIL rstmid_after valid=%0b data=%0h level=%0d exp 1/3c/0", tx_data_valid, tx_data, level); end
    tx_data_ack = 1'b1; tick(); tx_data_ack = 1'b0;
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL rstmid_idle got=%0b exp=1", idle); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_wrap();
    test_tx_en_gating();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
